// File: rtl/mem_responder.sv
// mem_responder: memory-side model for the dcache memory interface.
// A word-addressed RAM answers each captured request after a fixed,
// programmable latency with a one-cycle mem_ready pulse. Requests are
// strictly serialized (IDLE -> BUSY -> RESP), so a write followed by a read
// of the same word always observes the new data. Saturating read and write
// counters expose traffic for hit/miss analysis.
module mem_responder #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH        = 1024,
    parameter int LATENCY      = 10,
    parameter int INIT_PATTERN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count
);

    localparam int IDX_W = $clog2(DEPTH);
    // Counter only needs to hold LATENCY-1.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef logic [DATA_WIDTH-1:0] ram_t [DEPTH];

    // Power-up image: either each word holds its own byte address, or zero.
    function automatic ram_t ram_init();
        ram_t r;
        for (int i = 0; i < DEPTH; i++) begin
            r[i] = (INIT_PATTERN != 0) ? DATA_WIDTH'(i * 4) : '0;
        end
        return r;
    endfunction

    // RAM contents are loaded at configuration time only; reset never touches them.
    ram_t ram_q = ram_init();

    state_t                  state_q,  state_d;
    logic [CNT_W-1:0]        cnt_q,    cnt_d;
    logic                    we_q,     we_d;
    logic [IDX_W-1:0]        idx_q,    idx_d;
    logic [DATA_WIDTH-1:0]   wdata_q,  wdata_d;
    logic                    ready_q,  ready_d;
    logic [DATA_WIDTH-1:0]   rdata_q,  rdata_d;
    logic [31:0]             rd_cnt_q, rd_cnt_d;
    logic [31:0]             wr_cnt_q, wr_cnt_d;
    logic                    do_access;

    // Byte-offset and alias bits of the address are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr;

    // Next-state logic: capture in IDLE, count down in BUSY, pulse and return via RESP.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        ready_d   = 1'b0;
        rdata_d   = rdata_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        do_access = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    we_d    = mem_we;
                    idx_d   = mem_addr[2 +: IDX_W];
                    wdata_d = mem_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    do_access = 1'b1;
                    ready_d   = 1'b1;
                    state_d   = S_RESP;
                    if (we_q) begin
                        if (wr_cnt_q != 32'hFFFF_FFFF) begin
                            wr_cnt_d = wr_cnt_q + 32'd1;
                        end
                    end else begin
                        rdata_d = ram_q[idx_q];
                        if (rd_cnt_q != 32'hFFFF_FFFF) begin
                            rd_cnt_d = rd_cnt_q + 32'd1;
                        end
                    end
                end
            end
            S_RESP: begin
                // Requests seen here are not captured; the initiator holds req until IDLE.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and response registers; reset abandons any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // RAM write port; only fires on the access cycle, which reset already blocks.
    always_ff @(posedge clk) begin
        if (do_access && we_q) begin
            ram_q[idx_q] <= wdata_q;
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign busy      = (state_q != S_IDLE);
    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed scenarios plus randomized traffic,
// checked against a word-array model of the memory and transaction counters.
module tb_mem_responder;

    localparam int LAT   = 10;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic        mem_ready, busy;
    logic [31:0] mem_rdata, rd_count, wr_count;

    logic        f_req, f_we;
    logic [31:0] f_addr, f_wdata;
    logic        f_ready, f_busy;
    logic [31:0] f_rdata, f_rd_count, f_wr_count;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int dbl_cnt = 0;
    int pulses = 0;
    logic prev_rdy = 1'b0;

    // Reference state
    logic [31:0] mem_m [DEPTH];
    logic [31:0] rd_exp, wr_exp, last_rd;
    int          exp_pulses;
    int          f_rd_exp;

    mem_responder #(.LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(req), .mem_we(we), .mem_addr(addr), .mem_wdata(wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    mem_responder #(.LATENCY(1)) u_fast (
        .clk(clk), .rst_n(rst_n),
        .mem_req(f_req), .mem_we(f_we), .mem_addr(f_addr), .mem_wdata(f_wdata),
        .mem_ready(f_ready), .mem_rdata(f_rdata), .busy(f_busy),
        .rd_count(f_rd_count), .wr_count(f_wr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor on the main instance
    always @(negedge clk) begin
        prev_rdy <= mem_ready;
        if (mem_ready && prev_rdy) dbl_cnt <= dbl_cnt + 1;
        if (mem_ready) pulses <= pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic drop);
        int   lat;
        logic seen;
        logic [31:0] exp_rd;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        chk("cap_busy", {31'b0, busy}, 32'd1);
        if (drop) begin
            req = 1'b0; we = ~w; addr = $urandom; wdata = $urandom;
        end else begin
            addr = $urandom; wdata = $urandom;
        end
        seen = 1'b0; lat = 0;
        for (int k = 1; k <= LAT + 4; k++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                lat = k; seen = 1'b1;
                break;
            end
        end
        chk("ready_seen", {31'b0, seen}, 32'd1);
        if (seen) begin
            chk("latency", lat, LAT);
            if (w) begin
                mem_m[widx(a)] = d;
                wr_exp = wr_exp + 1;
                chk("wr_rdata_hold", mem_rdata, last_rd);
            end else begin
                exp_rd  = mem_m[widx(a)];
                last_rd = exp_rd;
                rd_exp  = rd_exp + 1;
                chk("rdata", mem_rdata, exp_rd);
            end
            chk("rd_count", rd_count, rd_exp);
            chk("wr_count", wr_count, wr_exp);
            exp_pulses++;
            // RESP edge: a still-held req must not be captured
            @(posedge clk); #1;
            req = 1'b0;
            chk("resp_ready_low", {31'b0, mem_ready}, 32'd0);
            chk("resp_no_recap", {31'b0, busy}, 32'd0);
        end
        req = 1'b0;
        $display("txn we=%0b addr=%h wdata=%h drop=%0b lat=%0d rdata=%h rd=%0d wr=%0d",
                 w, a, d, drop, lat, mem_rdata, rd_count, wr_count);
    endtask

    task automatic b2b(input int n);
        int last;
        logic seen;
        logic [31:0] a;
        a = $urandom;
        last = -1;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = a;
        for (int p = 0; p < n; p++) begin
            seen = 1'b0;
            for (int k = 0; k < LAT + 6; k++) begin
                @(posedge clk); #1;
                if (mem_ready) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("b2b_seen", {31'b0, seen}, 32'd1);
            if (!seen) break;
            rd_exp  = rd_exp + 1;
            last_rd = mem_m[widx(a)];
            exp_pulses++;
            chk("b2b_rdata", mem_rdata, last_rd);
            chk("b2b_rd_count", rd_count, rd_exp);
            if (last >= 0) chk("b2b_spacing", cyc - last, LAT + 2);
            $display("b2b pulse=%0d addr=%h rdata=%h cyc=%0d", p, a, mem_rdata, cyc);
            last = cyc;
            a = $urandom;
            addr = a;
            @(posedge clk); #1;
            chk("b2b_pulse_low", {31'b0, mem_ready}, 32'd0);
        end
        req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic fast_read(input logic [31:0] a);
        @(negedge clk);
        f_req = 1'b1; f_we = 1'b0; f_addr = a;
        @(posedge clk); #1;
        chk("f_cap_busy", {31'b0, f_busy}, 32'd1);
        f_req = 1'b0;
        @(posedge clk); #1;
        f_rd_exp++;
        chk("f_ready", {31'b0, f_ready}, 32'd1);
        chk("f_rdata", f_rdata, widx(a) * 4);
        chk("f_rd_count", f_rd_count, f_rd_exp);
        @(posedge clk); #1;
        chk("f_ready_low", {31'b0, f_ready}, 32'd0);
        $display("fast read addr=%h rdata=%h rd=%0d", a, f_rdata, f_rd_count);
    endtask

    task automatic reset_model();
        rd_exp = '0; wr_exp = '0; last_rd = '0; f_rd_exp = 0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = i * 4;
        reset_model();
        exp_pulses = 0;
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        f_req = 1'b0; f_we = 1'b0; f_addr = '0; f_wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", {31'b0, mem_ready}, 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_rd_count", rd_count, 32'd0);
        chk("rst_wr_count", wr_count, 32'd0);

        // Directed: read, write-then-read, aliasing
        run_txn(1'b0, 32'h10, 32'h0, 1'b0);
        run_txn(1'b1, 32'h40, 32'hDEADBEEF, 1'b0);
        run_txn(1'b0, 32'h40, 32'h0, 1'b0);
        run_txn(1'b0, 32'h1040, 32'h0, 1'b0);
        run_txn(1'b0, 32'h42, 32'h0, 1'b0);
        chk("alias_value", last_rd, 32'hDEADBEEF);

        // Back-to-back with req held
        b2b(4);

        // req dropped mid-BUSY
        run_txn(1'b0, 32'h84, 32'h0, 1'b1);
        run_txn(1'b1, 32'h88, 32'hCAFE0001, 1'b1);

        // Reset 5 edges into a write of 0x80
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h80; wdata = 32'h1234;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        reset_model();
        for (int k = 0; k < LAT + 4; k++) begin
            @(posedge clk); #1;
            if (k == 2) rst_n = 1'b1;
            if (mem_ready) chk("abort_no_ready", {31'b0, mem_ready}, 32'd0);
        end
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_wr_count", wr_count, 32'd0);
        chk("abort_rdata", mem_rdata, 32'd0);
        run_txn(1'b0, 32'h80, 32'h0, 1'b0);
        chk("abort_ram_kept", last_rd, 32'h80);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        // LATENCY=1 instance
        for (int t = 0; t < 6; t++) fast_read($urandom);
        chk("f_wr_count", f_wr_count, 32'd0);

        @(negedge clk);
        chk("no_double_ready", dbl_cnt, 0);
        chk("pulse_total", pulses, exp_pulses);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
